// File: rtl/grid_io_pad_driver_bottom.sv
// grid_io_pad_driver_bottom
// Drives the bottom IO tile of the Tiny Tapeout FPGA fabric from a byte stream.
// Each byte accepted on the in_valid/in_ready stream goes out on the 4 GPIN pads
// as two nibbles, low nibble first. Each nibble is held for HOLD_CYCLES cycles.
// The synchronized GPOUT pad is sampled at the end of every nibble window. The
// samples are packed into CAP_WIDTH-bit words, with the oldest sample in the MSB.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    byte to drive ([3:0] first, [7:4] second)
//   in_valid   in_data valid
//   in_ready   block accepts in_data this cycle (registered, high only in IDLE)
//   gpin_pad   nibble driven onto GPIN pads 0..3
//   gpout_pad  GPOUT pad, asynchronous to clk
//   cap_data   packed GPOUT samples, oldest sample in MSB
//   cap_valid  cap_data valid, held until cap_ready
//   cap_ready  consumer takes cap_data
//   busy       high whenever the FSM is not in IDLE
module grid_io_pad_driver_bottom #(
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CAP_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           gpin_pad,
  input  logic                 gpout_pad,
  output logic [CAP_WIDTH-1:0] cap_data,
  output logic                 cap_valid,
  input  logic                 cap_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRV_LO = 2'd1,
    DRV_HI = 2'd2,
    PUSH   = 2'd3
  } state_t;

  localparam int                CNT_W     = $clog2(CAP_WIDTH + 1);
  localparam logic [7:0]        HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CAP_LAST  = CNT_W'(CAP_WIDTH - 1);

  state_t                 state_r;
  logic [7:0]             hold_cnt_r;
  logic [3:0]             hi_nib_r;
  logic [CNT_W-1:0]       samp_cnt_r;
  logic [CAP_WIDTH-1:0]   shift_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   in_ready_r;
  logic                   busy_r;
  logic [3:0]             gpin_r;
  logic [CAP_WIDTH-1:0]   cap_data_r;
  logic                   cap_valid_r;

  logic gpo_s;
  logic transfer_s;
  logic fire_s;
  logic load_s;

  assign gpo_s      = sync_r[SYNC_STAGES-1];
  assign transfer_s = in_valid && in_ready_r;
  assign fire_s     = cap_valid_r && cap_ready;
  // The word can be loaded when the output slot is empty or is drained this cycle.
  assign load_s     = (state_r == PUSH) && (!cap_valid_r || cap_ready);

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign gpin_pad  = gpin_r;
  assign cap_data  = cap_data_r;
  assign cap_valid = cap_valid_r;

  // Multi-flop synchronizer bringing the GPOUT pad into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], gpout_pad};
    end
  end

  // Byte/nibble sequencer with capture packing.
  // in_ready and busy are registered from the next state, so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hold_cnt_r  <= 8'd0;
      hi_nib_r    <= 4'd0;
      samp_cnt_r  <= '0;
      shift_r     <= '0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      gpin_r      <= 4'd0;
      cap_data_r  <= '0;
      cap_valid_r <= 1'b0;
    end else begin
      // A drained word drops cap_valid; a PUSH reload below overrides this.
      if (fire_s) begin
        cap_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (transfer_s) begin
            gpin_r     <= in_data[3:0];
            hi_nib_r   <= in_data[7:4];
            hold_cnt_r <= HOLD_LOAD;
            state_r    <= DRV_LO;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            // Also raises in_ready on the first cycle after reset release.
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        DRV_LO: begin
          if (hold_cnt_r == 8'd0) begin
            shift_r    <= {shift_r[CAP_WIDTH-2:0], gpo_s};
            samp_cnt_r <= samp_cnt_r + CNT_W'(1);
            gpin_r     <= hi_nib_r;
            hold_cnt_r <= HOLD_LOAD;
            state_r    <= DRV_HI;
          end else begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
          end
        end
        DRV_HI: begin
          if (hold_cnt_r == 8'd0) begin
            shift_r    <= {shift_r[CAP_WIDTH-2:0], gpo_s};
            samp_cnt_r <= samp_cnt_r + CNT_W'(1);
            if (samp_cnt_r == CAP_LAST) begin
              state_r <= PUSH;
            end else begin
              state_r    <= IDLE;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b0;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
          end
        end
        PUSH: begin
          if (load_s) begin
            cap_data_r  <= shift_r;
            cap_valid_r <= 1'b1;
            samp_cnt_r  <= '0;
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            state_r <= PUSH;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_io_pad_driver_bottom.sv
// tb_grid_io_pad_driver_bottom
// Self-checking bench for grid_io_pad_driver_bottom (HOLD=4, SYNC=2, CAP=8).
// A timestamp-based reference model runs alongside the DUT. Each accepted byte
// records its accept edge, and its nibble and sample events follow from that edge.
// Each GPOUT sample is the pad value SYNC_STAGES edges before the sample edge.
// Samples queue up and are packed into a word when CAP_WIDTH of them are present.
module tb_grid_io_pad_driver_bottom;
  localparam int H  = 4;
  localparam int S  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    gpin_pad;
  logic          gpout_pad = 1'b0;
  logic [CW-1:0] cap_data;
  logic          cap_valid;
  logic          cap_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  grid_io_pad_driver_bottom #(.HOLD_CYCLES(H), .SYNC_STAGES(S), .CAP_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .gpin_pad(gpin_pad), .gpout_pad(gpout_pad),
    .cap_data(cap_data), .cap_valid(cap_valid), .cap_ready(cap_ready), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int            n;
  bit            m_act, m_push, m_rdy, m_cv;
  int            m_start;
  logic [7:0]    m_byte;
  logic [3:0]    m_gpin;
  logic [CW-1:0] m_cd;
  bit            samp_q[$];
  bit            pad_hist[0:8191];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_act = 0; m_push = 0; m_rdy = 0; m_cv = 0;
    m_start = 0; m_byte = 8'd0; m_gpin = 4'd0; m_cd = '0;
    samp_q.delete();
  endtask

  function automatic bit pad_at(input int k);
    if (k < 1) return 1'b0;
    return pad_hist[k % 8192];
  endfunction

  task automatic model_edge();
    bit fire;
    bit ld;
    int d;
    fire = m_cv && cap_ready;
    ld = 0;
    if (m_push) begin
      if (!m_cv || cap_ready) begin
        m_cd = '0;
        foreach (samp_q[i]) m_cd[CW-1-i] = samp_q[i];
        samp_q.delete();
        ld = 1; m_push = 0;
      end
    end else if (m_act) begin
      d = n - m_start;
      if (d == H) begin
        samp_q.push_back(pad_at(n - S));
        m_gpin = m_byte[7:4];
      end else if (d == 2 * H) begin
        samp_q.push_back(pad_at(n - S));
        m_act = 0;
        if (samp_q.size() == CW) m_push = 1;
      end
    end else if (m_rdy && in_valid) begin
      m_act = 1; m_start = n; m_byte = in_data; m_gpin = in_data[3:0];
    end
    m_cv  = ld ? 1'b1 : (fire ? 1'b0 : m_cv);
    m_rdy = !m_act && !m_push;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      n++;
      pad_hist[n % 8192] = gpout_pad;
      model_edge();
    end
    #1;
    chk("in_ready", in_ready, m_rdy);
    chk("busy", busy, m_act || m_push);
    chk("gpin_pad", gpin_pad, m_gpin);
    chk("cap_valid", cap_valid, m_cv);
    chk("cap_data", cap_data, m_cd);
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (in_ready) return;
      tick();
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // d = cycles before the sample edge at which the pad toggles
  task automatic sync_byte(input logic [7:0] b, input int d);
    send_byte(b);
    for (int j = 0; j < 2 * H; j++) begin
      if (j == H - d) gpout_pad = 1'b1;
      if (j == 2 * H - d) gpout_pad = 1'b0;
      tick();
    end
  endtask

  int lo_cnt, hi_cnt, nr_cnt, acc, cyc;
  bit take;

  initial begin
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rdy_first", in_ready, 1'b1);

    // capture word from a per-byte constant pad level
    for (int i = 0; i < 4; i++) begin
      gpout_pad = (i % 2 == 0);
      send_byte(8'($urandom));
      wait_idle();
    end
    chk("cap_word", cap_data, 8'b1100_1100);
    chk("cap_vld", cap_valid, 1'b1);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    chk("cap_clr", cap_valid, 1'b0);

    // nibble timing for 0xA5
    gpout_pad = 1'($urandom);
    send_byte(8'hA5);
    lo_cnt = 0; hi_cnt = 0; nr_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      if (gpin_pad == 4'h5) lo_cnt++;
      else if (gpin_pad == 4'hA) hi_cnt++;
      nr_cnt++;
      tick();
    end
    chk("lo_hold", lo_cnt, 4);
    chk("hi_hold", hi_cnt, 4);
    chk("rdy_low", nr_cnt, 8);

    // backpressure: the second word stalls in PUSH
    for (int i = 0; i < 7; i++) begin
      gpout_pad = 1'($urandom);
      send_byte(8'($urandom));
    end
    repeat (2 * H + 2) tick();
    chk("bp_busy", busy, 1'b1);
    chk("bp_rdy", in_ready, 1'b0);
    chk("bp_vld", cap_valid, 1'b1);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    chk("bp_reload", cap_valid, 1'b1);
    send_byte(8'($urandom));

    // async reset in the middle of DRV_HI, with a word still pending
    gpout_pad = 1'b0;
    wait_idle();
    send_byte(8'h3C);
    repeat (H + 1) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_gpin", gpin_pad, 4'd0);
    chk("rst_vld", cap_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_data", cap_data, 8'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rdy_rel", in_ready, 1'b1);

    // synchronizer latency: late toggles give the old value, early toggles the new value
    gpout_pad = 1'b0;
    for (int i = 0; i < 4; i++) sync_byte(8'($urandom), (i % 2 == 0) ? 1 : 3);
    wait_idle();
    chk("sync_word", cap_data, 8'b0110_0110);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;

    // back-to-back bytes with in_valid held high
    acc = 0; cyc = 0;
    in_data = 8'h11; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      take = in_ready && in_valid;
      tick();
      if (acc > 0 || take) cyc++;
      if (take) begin
        acc++;
        if (acc < 3) in_data = 8'(8'h11 * (acc + 1));
        else in_valid = 1'b0;
      end
      if (acc == 3 && in_ready) break;
    end
    in_valid = 1'b0;
    chk("b2b_acc", acc, 3);
    chk("b2b_cyc", cyc, 3 * (2 * H + 1));

    // randomized traffic checked against the model every cycle
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      cap_ready = ($urandom_range(3) == 0);
      gpout_pad = 1'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    cap_ready = 1'b1;
    repeat (2 * H + 4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
